// File: rtl/micro_sequencer_if.sv
`default_nettype none
// ============================================================================
// Module      : micro_sequencer_if
// Description : Bus between the microprogram sequencer and the control-store /
//               datapath side. It carries the sequencing fields of the current
//               control word, status flags and opcode into the sequencer, and
//               carries the registered microaddress and status back out.
//   master : the sequencer. It drives addr, cw_valid, halted and err_code.
//   slave  : the control store / datapath. It drives next_field, seq_sel,
//            cond_sel, flags, opcode, stall and call.
// Revision    : 1.0 - initial release
// ============================================================================
interface micro_sequencer_if #(
  parameter int ADDR_W = 5
) ();
  logic [ADDR_W-1:0] next_field;  // branch / jump target field
  logic [1:0]        seq_sel;     // 11 jump, 01 cond, 10 dispatch, 00 return
  logic [1:0]        cond_sel;    // flag selector for conditional branch
  logic [3:0]        flags;       // datapath status flags
  logic [3:0]        opcode;      // macro-instruction opcode for dispatch
  logic              stall;       // freeze sequencing while high
  logic              call;        // push-on-jump request
  logic [ADDR_W-1:0] addr;        // registered microaddress
  logic              cw_valid;    // control word live (EXEC)
  logic              halted;      // sticky trap indicator
  logic [1:0]        err_code;    // trap cause

  modport master (
    input  next_field, seq_sel, cond_sel, flags, opcode, stall, call,
    output addr, cw_valid, halted, err_code
  );

  modport slave (
    output next_field, seq_sel, cond_sel, flags, opcode, stall, call,
    input  addr, cw_valid, halted, err_code
  );
endinterface
`default_nettype wire

// File: rtl/micro_sequencer.sv
`default_nettype none
// ============================================================================
// Module      : micro_sequencer
// Description : Next-address generator for the microprogram control store.
//               It runs a two-cycle microinstruction period: EXEC evaluates the
//               sequencing fields and issues the next address, then WAIT lets
//               the store register the new word. The block supports jump,
//               conditional branch, opcode dispatch and return-to-fetch. A
//               target above MAX_ADDR traps into HALT, and only reset leaves
//               HALT.
//   Optional    : define USEQ_RET_STACK_EN to enable a STACK_DEPTH-entry
//                 return stack. With it, a jump with call=1 pushes addr+1 and
//                 a return pops the stack.
// Ports       :
//   clk    in   clock
//   reset  in   synchronous active-high reset
//   bus    master modport of micro_sequencer_if (control-word fields, flags,
//          opcode, stall, call in; addr, cw_valid, halted, err_code out)
// Revision    : 1.0 - initial release
// ============================================================================
module micro_sequencer #(
  parameter int ADDR_W      = 5,
  parameter int MAX_ADDR    = 24,
  parameter int RESET_ADDR  = 8,
  parameter int FETCH_ADDR  = 1,
  parameter int DISP_BASE   = 9,
  parameter int STACK_DEPTH = 4
) (
  input  wire               clk,
  input  wire               reset,
  micro_sequencer_if.master bus
);

  localparam logic [ADDR_W:0]   c_max_addr   = (ADDR_W+1)'(MAX_ADDR);
  localparam logic [ADDR_W:0]   c_fetch_addr = (ADDR_W+1)'(FETCH_ADDR);
  localparam logic [ADDR_W-1:0] c_reset_addr = ADDR_W'(RESET_ADDR);

  localparam logic [1:0] c_err_none  = 2'b00;
  localparam logic [1:0] c_err_addr  = 2'b01;
  localparam logic [1:0] c_err_ovf   = 2'b10;

  localparam logic [1:0] c_seq_ret   = 2'b00;
  localparam logic [1:0] c_seq_cond  = 2'b01;
  localparam logic [1:0] c_seq_disp  = 2'b10;
  localparam logic [1:0] c_seq_jump  = 2'b11;

  typedef enum logic [1:0] {
    S_EXEC = 2'd0,
    S_WAIT = 2'd1,
    S_HALT = 2'd2
  } state_t;

  state_t            state_q;
  logic [ADDR_W-1:0] addr_q;
  logic              cw_valid_q;
  logic              halted_q;
  logic [1:0]        err_q;

  // Targets are carried one bit wider than addr so that a not-taken branch
  // from the top word (24+1) stays visible as an illegal value.
  logic [ADDR_W:0]   target_d;
  logic [ADDR_W:0]   addr_inc_d;
  logic [ADDR_W-1:0] disp_d;
  logic              push_ovf_d;

`ifdef USEQ_RET_STACK_EN
  localparam int SP_W = $clog2(STACK_DEPTH + 1);
  localparam logic [SP_W-1:0] c_sp_full = SP_W'(STACK_DEPTH);

  // Entries keep the full ADDR_W+1 bits so that an out-of-range return
  // address can be trapped when it is popped.
  logic [ADDR_W:0]   stack_q [STACK_DEPTH];
  logic [SP_W-1:0]   sp_q;
  logic [ADDR_W:0]   stack_top_d;
`else
  logic unused_sigs;
  assign unused_sigs = bus.call ^ (STACK_DEPTH > 0);
`endif

  assign bus.addr     = addr_q;
  assign bus.cw_valid = cw_valid_q;
  assign bus.halted   = halted_q;
  assign bus.err_code = err_q;

  always_comb begin
    addr_inc_d = {1'b0, addr_q} + (ADDR_W+1)'(1);
    // Dispatch wraps modulo 2**ADDR_W before the range check.
    disp_d     = ADDR_W'(DISP_BASE) + ADDR_W'(bus.opcode);
    push_ovf_d = 1'b0;
`ifdef USEQ_RET_STACK_EN
    stack_top_d = '0;
    for (int i = 0; i < STACK_DEPTH; i++) begin
      if (sp_q == SP_W'(i + 1)) stack_top_d = stack_q[i];
    end
`endif
    case (bus.seq_sel)
      c_seq_jump: target_d = {1'b0, bus.next_field};
      c_seq_cond: target_d = bus.flags[bus.cond_sel] ? {1'b0, bus.next_field}
                                                     : addr_inc_d;
      c_seq_disp: target_d = {1'b0, disp_d};
      default:    target_d = c_fetch_addr;
    endcase
`ifdef USEQ_RET_STACK_EN
    if (bus.seq_sel == c_seq_jump && bus.call && sp_q == c_sp_full)
      push_ovf_d = 1'b1;
    if (bus.seq_sel == c_seq_ret && sp_q != '0)
      target_d = stack_top_d;
`endif
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q    <= S_EXEC;
      addr_q     <= c_reset_addr;
      cw_valid_q <= 1'b1;
      halted_q   <= 1'b0;
      err_q      <= c_err_none;
`ifdef USEQ_RET_STACK_EN
      sp_q       <= '0;
`endif
    end else begin
      case (state_q)
        S_EXEC: begin
          if (!bus.stall) begin
            if (push_ovf_d || target_d > c_max_addr) begin
              state_q    <= S_HALT;
              addr_q     <= c_reset_addr;
              cw_valid_q <= 1'b0;
              halted_q   <= 1'b1;
              err_q      <= push_ovf_d ? c_err_ovf : c_err_addr;
            end else begin
              state_q    <= S_WAIT;
              addr_q     <= target_d[ADDR_W-1:0];
              cw_valid_q <= 1'b0;
`ifdef USEQ_RET_STACK_EN
              if (bus.seq_sel == c_seq_jump && bus.call) begin
                for (int i = 0; i < STACK_DEPTH; i++) begin
                  if (sp_q == SP_W'(i)) stack_q[i] <= addr_inc_d;
                end
                sp_q <= sp_q + SP_W'(1);
              end else if (bus.seq_sel == c_seq_ret && sp_q != '0) begin
                sp_q <= sp_q - SP_W'(1);
              end
`endif
            end
          end
        end
        S_WAIT: begin
          // stall is deliberately ignored here; the store always needs
          // this cycle to register the new word.
          state_q    <= S_EXEC;
          cw_valid_q <= 1'b1;
        end
        S_HALT: begin
          addr_q     <= c_reset_addr;
          cw_valid_q <= 1'b0;
          halted_q   <= 1'b1;
        end
        default: begin
          state_q    <= S_HALT;
          addr_q     <= c_reset_addr;
          cw_valid_q <= 1'b0;
          halted_q   <= 1'b1;
        end
      endcase
    end
  end

endmodule
`default_nettype wire
